// File: rtl/keccak_arbiter.sv
// keccak_arbiter: round-robin sharing of one Keccak hash core among N_REQ
// requesters, with digest capture, timeout/abort handling and core reset.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req[N]                per-requester job request (held until done/err)
//   req_in[32N]           per-requester data word (requester k: [32k+31:32k])
//   req_in_ready[N]       per-requester word valid
//   req_is_last[N]        per-requester last-word flag
//   req_byte_num[2N]      per-requester valid bytes in the last word
//   req_buffer_full[N]    per-requester backpressure (1 unless streaming)
//   gnt[N]                registered one-hot grant
//   done[N], err[N]       one-cycle completion / abort pulses
//   digest[512]           last captured digest
//   core_reset            reset to the core (reset or CLEAR state)
//   core_in, core_in_ready, core_is_last, core_byte_num   word to the core
//   core_buffer_full      core backpressure
//   core_out, core_out_ready   core digest and its sticky valid
module keccak_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  req_in,
    input  logic [N_REQ-1:0]     req_in_ready,
    input  logic [N_REQ-1:0]     req_is_last,
    input  logic [2*N_REQ-1:0]   req_byte_num,
    output logic [N_REQ-1:0]     req_buffer_full,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err,
    output logic [511:0]         digest,
    output logic                 core_reset,
    output logic [31:0]          core_in,
    output logic                 core_in_ready,
    output logic                 core_is_last,
    output logic [1:0]           core_byte_num,
    input  logic                 core_buffer_full,
    input  logic [511:0]         core_out,
    input  logic                 core_out_ready
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] G_MAX   = IW'(N_REQ - 1);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        STREAM,
        WAIT
    } state_t;

    state_t state, state_nxt;

    logic [IW-1:0] g;
    logic [IW-1:0] rr;
    logic [IW-1:0] rr_nxt;
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          abort;
    logic          fin_ok;
    logic          fin_to;

    // Round-robin search: walk offsets from the highest down so the
    // lowest offset from rr is the one that sticks.
    always_comb begin
        pick  = rr;
        found = 1'b0;
        idx   = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(rr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
    end

    assign rr_nxt     = (g == G_MAX) ? '0 : g + IW'(1);
    assign core_reset = reset | (state == CLEAR);

    always_ff @(posedge clk) begin
        if (reset) state <= CLEAR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        accept          = 1'b0;
        abort           = 1'b0;
        fin_ok          = 1'b0;
        fin_to          = 1'b0;
        core_in_ready   = 1'b0;
        core_is_last    = 1'b0;
        req_buffer_full = '1;
        core_in         = req_in[{g, 5'b0} +: 32];
        core_byte_num   = req_byte_num[{g, 1'b0} +: 2];
        case (state)
            CLEAR: state_nxt = IDLE;
            IDLE: begin
                if (found) state_nxt = STREAM;
            end
            STREAM: begin
                core_in_ready      = req_in_ready[g];
                core_is_last       = req_is_last[g];
                req_buffer_full[g] = core_buffer_full;
                accept = req_in_ready[g] & ~core_buffer_full;
                if (!req[g]) begin
                    abort     = 1'b1;
                    state_nxt = CLEAR;
                end else if (accept && req_is_last[g]) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A ready digest beats a timeout landing on the same cycle.
                if (!req[g]) begin
                    abort     = 1'b1;
                    state_nxt = CLEAR;
                end else if (core_out_ready) begin
                    fin_ok    = 1'b1;
                    state_nxt = CLEAR;
                end else if (cnt == TO_LAST) begin
                    fin_to    = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt    <= '0;
            done   <= '0;
            err    <= '0;
            digest <= '0;
            rr     <= '0;
            g      <= '0;
            cnt    <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            // Counter sits at zero outside WAIT, so it is clear on entry.
            if (state == WAIT) cnt <= cnt + CW'(1);
            else               cnt <= '0;
            if (state == IDLE && found) begin
                gnt <= N_REQ'(1) << pick;
                g   <= pick;
            end
            if (fin_ok) begin
                done[g] <= 1'b1;
                digest  <= core_out;
            end
            if (abort || fin_to) err[g] <= 1'b1;
            if (abort || fin_ok || fin_to) begin
                gnt <= '0;
                rr  <= rr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_keccak_arbiter.sv
// tb_keccak_arbiter: directed jobs against a behavioural arbiter model and
// a simple checksum core stub; per-cycle output comparison plus literals.
module tb_keccak_arbiter;

    localparam int NR  = 4;
    localparam int TO  = 16;
    localparam int LAT = 3;
    localparam int P_CLR  = 0;
    localparam int P_IDLE = 1;
    localparam int P_STR  = 2;
    localparam int P_WAIT = 3;

    logic clk = 1'b0;
    logic reset;
    logic [NR-1:0]    req;
    logic [32*NR-1:0] req_in;
    logic [NR-1:0]    req_in_ready;
    logic [NR-1:0]    req_is_last;
    logic [2*NR-1:0]  req_byte_num;
    logic [NR-1:0]    req_buffer_full;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    done;
    logic [NR-1:0]    err;
    logic [511:0]     digest;
    logic             core_reset;
    logic [31:0]      core_in;
    logic             core_in_ready;
    logic             core_is_last;
    logic [1:0]       core_byte_num;
    logic             core_buffer_full;
    logic [511:0]     core_out;
    logic             core_out_ready;

    int checks = 0;
    int errors = 0;

    keccak_arbiter #(.N_REQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_in(req_in),
        .req_in_ready(req_in_ready),
        .req_is_last(req_is_last),
        .req_byte_num(req_byte_num),
        .req_buffer_full(req_buffer_full),
        .gnt(gnt),
        .done(done),
        .err(err),
        .digest(digest),
        .core_reset(core_reset),
        .core_in(core_in),
        .core_in_ready(core_in_ready),
        .core_is_last(core_is_last),
        .core_byte_num(core_byte_num),
        .core_buffer_full(core_buffer_full),
        .core_out(core_out),
        .core_out_ready(core_out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] got,
                       input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Core stub: digest = {count, sum, xor, byte_num} of absorbed words.
    logic [31:0] s_cnt, s_sum, s_x;
    logic [1:0]  s_bn;
    logic        s_last, s_rdy;
    int          s_lat;
    logic        hang;

    always @(posedge clk) begin
        if (core_reset) begin
            s_cnt  <= '0;
            s_sum  <= '0;
            s_x    <= '0;
            s_bn   <= '0;
            s_last <= 1'b0;
            s_rdy  <= 1'b0;
            s_lat  <= 0;
        end else begin
            if (core_in_ready && !core_buffer_full && !s_last) begin
                s_cnt <= s_cnt + 32'd1;
                s_sum <= s_sum + core_in;
                s_x   <= s_x ^ core_in;
                if (core_is_last) begin
                    s_last <= 1'b1;
                    s_bn   <= core_byte_num;
                    s_lat  <= LAT;
                end
            end
            if (s_last && !s_rdy && !hang) begin
                if (s_lat == 0) s_rdy <= 1'b1;
                else            s_lat <= s_lat - 1;
            end
        end
    end

    assign core_out       = {384'h0, s_cnt, s_sum, s_x, 30'h0, s_bn};
    assign core_out_ready = s_rdy;

    // Behavioural model of the arbiter.
    int ph, own, m_rr, wcnt, cyc;
    logic [NR-1:0] m_gnt, m_done, m_err;
    logic [511:0]  m_digest;
    logic [1:0]    m_bn;
    logic [31:0]   mq[$];
    bit            started;

    function automatic logic [511:0] digest_of();
        logic [31:0] s = '0;
        logic [31:0] x = '0;
        foreach (mq[i]) begin
            s += mq[i];
            x ^= mq[i];
        end
        return {384'h0, 32'(mq.size()), s, x, 30'h0, m_bn};
    endfunction

    task automatic end_job(input bit ok);
        if (ok) begin
            m_done[own] = 1'b1;
            m_digest    = digest_of();
        end else begin
            m_err[own] = 1'b1;
        end
        m_gnt = '0;
        m_rr  = (own + 1) % NR;
        ph    = P_CLR;
    endtask

    task automatic model_step();
        bit hit = 0;
        int k;
        m_done = '0;
        m_err  = '0;
        if (reset) begin
            ph = P_CLR;
            m_gnt = '0;
            m_digest = '0;
            m_rr = 0;
            return;
        end
        case (ph)
            P_CLR: ph = P_IDLE;
            P_IDLE: begin
                for (int i = 0; i < NR; i++) begin
                    k = (m_rr + i) % NR;
                    if (!hit && req[k]) begin
                        hit = 1;
                        own = k;
                    end
                end
                if (hit) begin
                    m_gnt = '0;
                    m_gnt[own] = 1'b1;
                    mq.delete();
                    ph = P_STR;
                end
            end
            P_STR: begin
                if (!req[own]) end_job(0);
                else if (req_in_ready[own] && !core_buffer_full) begin
                    mq.push_back(req_in[32*own +: 32]);
                    if (req_is_last[own]) begin
                        m_bn = req_byte_num[2*own +: 2];
                        wcnt = 0;
                        ph = P_WAIT;
                    end
                end
            end
            default: begin
                if (!req[own]) end_job(0);
                else if (s_rdy) end_job(1);
                else if (wcnt == TO - 1) end_job(0);
                else wcnt++;
            end
        endcase
    endtask

    initial begin
        ph = P_CLR;
        own = 0;
        m_rr = 0;
        wcnt = 0;
        cyc = 0;
        m_gnt = '0;
        m_done = '0;
        m_err = '0;
        m_digest = '0;
        m_bn = '0;
        started = 0;
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            started = 1;
        end
    end

    // Per-cycle comparison against the model.
    logic [NR-1:0] exp_bf;
    logic exp_rdy, exp_last;

    initial forever begin
        @(negedge clk);
        if (started) begin
            exp_bf = '1;
            exp_rdy = 1'b0;
            exp_last = 1'b0;
            if (ph == P_STR) begin
                exp_bf[own] = core_buffer_full;
                exp_rdy = req_in_ready[own];
                exp_last = req_is_last[own];
                chk("core_in", core_in, req_in[32*own +: 32]);
                chk("core_byte_num", core_byte_num,
                    req_byte_num[2*own +: 2]);
            end
            chk("gnt", gnt, m_gnt);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("digest", digest, m_digest);
            chk("core_reset", core_reset, reset || ph == P_CLR);
            chk("core_in_ready", core_in_ready, exp_rdy);
            chk("core_is_last", core_is_last, exp_last);
            chk("req_buffer_full", req_buffer_full, exp_bf);
        end
    end

    // Backpressure pattern: 0 none, 1 every third cycle, 2 always full.
    int bf_mode;

    initial begin
        core_buffer_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (bf_mode)
                0: core_buffer_full = 1'b0;
                1: core_buffer_full = (cyc % 3 == 0);
                default: core_buffer_full = 1'b1;
            endcase
        end
    end

    int gnt_order[$];

    // One job for requester k: n words base*(j+1); drop req after
    // `drop` accepted words when drop >= 0. outcome: 1 done, 2 err, 3 none.
    task automatic run_job(input int k, input int n,
                           input logic [31:0] base, input logic [1:0] bn,
                           input int drop, output int outcome,
                           output int lat_gnt, output int lat_end);
        int wi = 0;
        int t0, tl;
        int budget = 0;
        logic acc;
        outcome = 0;
        lat_gnt = -1;
        req_in[32*k +: 32] = base;
        req_is_last[k] = (n == 1);
        req_byte_num[2*k +: 2] = bn;
        req_in_ready[k] = 1'b1;
        req[k] = 1'b1;
        t0 = cyc;
        while (wi < n && !(drop >= 0 && wi == drop)) begin
            @(negedge clk);
            if (gnt[k] && lat_gnt < 0) begin
                lat_gnt = cyc - t0;
                gnt_order.push_back(k);
            end
            acc = req_in_ready[k] && !req_buffer_full[k];
            @(posedge clk);
            #1;
            if (acc) begin
                wi++;
                req_in[32*k +: 32] = base * 32'(wi + 1);
                req_is_last[k] = (wi == n - 1);
            end
            budget++;
            if (budget > 3000) begin
                $display("FAIL job%0d_stream: got %0d words want %0d", k, wi, n);
                errors++;
                break;
            end
        end
        req_in_ready[k] = 1'b0;
        req_is_last[k] = 1'b0;
        if (drop >= 0 && wi == drop) req[k] = 1'b0;
        tl = cyc;
        budget = 0;
        while (outcome == 0) begin
            @(negedge clk);
            if (done[k]) outcome = 1;
            else if (err[k]) outcome = 2;
            else if (++budget > 200) begin
                $display("FAIL job%0d_end: got no done/err want a pulse", k);
                errors++;
                outcome = 3;
            end
        end
        lat_end = cyc - tl;
        @(posedge clk);
        #1;
        req[k] = 1'b0;
    endtask

    localparam logic [511:0] LIT1 = {384'h0, 32'd1, 32'h0, 32'h0, 32'h0};
    localparam logic [511:0] LIT2 =
        {384'h0, 32'd3, 32'h99999998, 32'h0, 32'd3};

    int oc, lg, le;
    int oc_a[NR], lg_a[NR], le_a[NR];
    logic [511:0] saved;
    int budget6;

    initial begin
        reset = 1'b1;
        req = '0;
        req_in = '0;
        req_in_ready = '0;
        req_is_last = '0;
        req_byte_num = '0;
        hang = 1'b0;
        bf_mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_digest", digest, 0);
        chk("rst_core_reset", core_reset, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: single empty-message word from requester 0
        run_job(0, 1, 32'h0, 2'd0, -1, oc, lg, le);
        chk("t1_outcome", oc, 1);
        chk("t1_gnt_latency", lg, 1);
        chk("t1_digest", digest, LIT1);
        chk("t1_model_pin", m_digest, LIT1);

        // 2: all four requesters at once, round-robin from 0
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        gnt_order.delete();
        fork
            run_job(0, 3, 32'h11111111, 2'd3, -1, oc_a[0], lg_a[0], le_a[0]);
            run_job(1, 3, 32'h22222222, 2'd3, -1, oc_a[1], lg_a[1], le_a[1]);
            run_job(2, 3, 32'h33333333, 2'd3, -1, oc_a[2], lg_a[2], le_a[2]);
            run_job(3, 3, 32'h44444444, 2'd3, -1, oc_a[3], lg_a[3], le_a[3]);
        join
        chk("t2_order_len", gnt_order.size(), 4);
        for (int i = 0; i < NR; i++) begin
            chk("t2_outcome", oc_a[i], 1);
            if (i < gnt_order.size()) chk("t2_order", gnt_order[i], i);
        end
        chk("t2_digest", digest, LIT2);
        chk("t2_model_pin", m_digest, LIT2);

        // 3: 40-word message with toggling core backpressure
        bf_mode = 1;
        run_job(2, 40, 32'h01020305, 2'd2, -1, oc, lg, le);
        bf_mode = 0;
        chk("t3_outcome", oc, 1);
        chk("t3_word_count", digest[127:96], 40);

        // 4: requester 1 aborts after 2 words, requester 2 follows
        gnt_order.delete();
        fork
            run_job(1, 5, 32'h0BADF00D, 2'd1, 2, oc_a[1], lg_a[1], le_a[1]);
            run_job(2, 3, 32'h00C0FFEE, 2'd0, -1, oc_a[2], lg_a[2], le_a[2]);
        join
        chk("t4_abort_outcome", oc_a[1], 2);
        chk("t4_next_outcome", oc_a[2], 1);
        chk("t4_order_len", gnt_order.size(), 2);
        if (gnt_order.size() == 2) begin
            chk("t4_order0", gnt_order[0], 1);
            chk("t4_order1", gnt_order[1], 2);
        end
        chk("t4_word_count", digest[127:96], 3);

        // 5: core never finishes -> timeout
        saved = m_digest;
        hang = 1'b1;
        run_job(3, 2, 32'h5A5A5A5A, 2'd1, -1, oc, lg, le);
        hang = 1'b0;
        chk("t5_outcome", oc, 2);
        chk("t5_timeout_latency", le, 16);
        chk("t5_digest_held", digest, saved);

        // 6: reset during STREAM
        bf_mode = 2;
        req_in[96 +: 32] = 32'hDEADBEEF;
        req_is_last[3] = 1'b0;
        req_in_ready[3] = 1'b1;
        req[3] = 1'b1;
        budget6 = 0;
        do begin
            @(negedge clk);
            budget6++;
        end while (!gnt[3] && budget6 < 20);
        chk("t6_granted", gnt[3], 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_gnt", gnt, 0);
        chk("t6_done", done, 0);
        chk("t6_err", err, 0);
        chk("t6_core_reset_in", core_reset, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req[3] = 1'b0;
        req_in_ready[3] = 1'b0;
        bf_mode = 0;
        @(negedge clk);
        chk("t6_core_reset_clear", core_reset, 1);
        @(negedge clk);
        chk("t6_core_reset_idle", core_reset, 0);
        @(posedge clk);
        #1;
        run_job(3, 3, 32'h00000777, 2'd0, -1, oc, lg, le);
        chk("t6_outcome", oc, 1);
        chk("t6_word_count", digest[127:96], 3);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
